// File: rtl/std_ram_pkg.sv
// Shared types and constants for the single-port RAM controller family.
package std_ram_pkg;

  // Default width of one byte-enable lane.
  localparam int unsigned BYTE_W_DEF = 8;

  // Controller FSM: StInit clears the array after reset, StRun serves requests.
  typedef enum logic [0:0] {
    StInit,
    StRun
  } state_e;

endpackage

// File: rtl/std_spram_core.sv
// Behavioural single-port RAM: per-lane write enable, registered read port.
// Read data holds its value on cycles without a read.
module std_spram_core
  import std_ram_pkg::*;
#(
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned BYTE_W = BYTE_W_DEF
) (
  input  logic                       clk_i,
  input  logic                       en_i,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   addr_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic [DATA_W/BYTE_W-1:0]   be_i,
  output logic [DATA_W-1:0]          rdata_o
);

  localparam int unsigned NB = DATA_W / BYTE_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Lane-masked write or registered read; the caller keeps addr_i in range.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][b*BYTE_W +: BYTE_W] <= wdata_i[b*BYTE_W +: BYTE_W];
        end
      end
    end
    if (en_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/std_spram_ctrl.sv
// Single-port RAM controller: valid/ready request port, fixed-latency read
// responses, out-of-range detection and an optional post-reset clear.
// Define STD_SPRAM_INIT_EN to enable the INIT clear sequence after reset.
module std_spram_ctrl
  import std_ram_pkg::*;
#(
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned BYTE_W  = BYTE_W_DEF,
  parameter int unsigned OUT_REG = 0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [$clog2(DEPTH)-1:0]   req_addr,
  input  logic [DATA_W-1:0]          req_wdata,
  input  logic [DATA_W/BYTE_W-1:0]   req_be,
  output logic                       rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  output logic                       init_busy
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned NB     = DATA_W / BYTE_W;
  // One extra bit so DEPTH itself is representable in the range compare.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_e state_q, state_d;

  logic acc, rd_acc, in_range;
  logic mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, core_rdata, rd_data;
  logic [NB-1:0]     mem_be;
  logic rd_p1_q, err_p1_q;

  assign in_range = ({1'b0, req_addr} < DEPTH_EXT);
  assign acc      = req_valid & req_ready;
  assign rd_acc   = acc & ~req_we;

`ifdef STD_SPRAM_INIT_EN
  logic [ADDR_W-1:0] clr_cnt_q;

  // Clear counter walks 0..DEPTH-1 while in INIT; reset restarts it at 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      clr_cnt_q <= '0;
    end else if (state_q == StInit) begin
      clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
    end
  end
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
`ifdef STD_SPRAM_INIT_EN
      state_q <= StInit;
`else
      state_q <= StRun;
`endif
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: INIT leaves after writing the last address; RUN is final.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StInit: begin
`ifdef STD_SPRAM_INIT_EN
        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) state_d = StRun;
`else
        state_d = StRun;
`endif
      end
      StRun: state_d = StRun;
    endcase
  end

  // FSM outputs.
  always_comb begin
    req_ready = (state_q == StRun);
    init_busy = 1'b0;
`ifdef STD_SPRAM_INIT_EN
    init_busy = (state_q == StInit);
`endif
  end

  // RAM port mux: the clear sequence owns the port during INIT.
  always_comb begin
    mem_en    = acc & in_range;
    mem_we    = req_we;
    mem_addr  = req_addr;
    mem_wdata = req_wdata;
    mem_be    = req_be;
`ifdef STD_SPRAM_INIT_EN
    if (state_q == StInit) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = clr_cnt_q;
      mem_wdata = '0;
      mem_be    = '1;
    end
`endif
  end

  std_spram_core #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .BYTE_W (BYTE_W)
  ) u_core (
    .clk_i   (CLK),
    .en_i    (mem_en),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .be_i    (mem_be),
    .rdata_o (core_rdata)
  );

  // Tracks the read issued to the core last cycle and whether it was out of range.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_p1_q  <= 1'b0;
      err_p1_q <= 1'b0;
    end else begin
      rd_p1_q  <= rd_acc;
      err_p1_q <= rd_acc & ~in_range;
    end
  end

  // Out-of-range reads never touched the core, so force their data to zero.
  assign rd_data = err_p1_q ? '0 : core_rdata;

  if (OUT_REG != 0) begin : g_out_reg
    logic              v_q, e_q;
    logic [DATA_W-1:0] d_q;

    // Extra response stage; data register holds between responses.
    always_ff @(posedge CLK) begin
      if (RST) begin
        v_q <= 1'b0;
        e_q <= 1'b0;
        d_q <= '0;
      end else begin
        v_q <= rd_p1_q;
        e_q <= rd_p1_q & err_p1_q;
        if (rd_p1_q) d_q <= rd_data;
      end
    end

    assign rsp_valid = v_q;
    assign rsp_err   = e_q;
    assign rsp_rdata = d_q;
  end else begin : g_no_out_reg
    logic [DATA_W-1:0] hold_q;
    logic              v;

    // Masking with RST drops a read that is in flight when reset arrives.
    assign v = rd_p1_q & ~RST;

    // Holds the last response so rsp_rdata is stable between responses.
    always_ff @(posedge CLK) begin
      if (RST) begin
        hold_q <= '0;
      end else if (rd_p1_q) begin
        hold_q <= rd_data;
      end
    end

    assign rsp_valid = v;
    assign rsp_err   = v & err_p1_q;
    assign rsp_rdata = v ? rd_data : hold_q;
  end

endmodule

// File: tb/tb_std_spram_ctrl.sv
// Bench for std_spram_ctrl: two instances (OUT_REG=0 and OUT_REG=1) share one
// request stream; a word/lane model predicts read data and a per-instance
// monitor checks every response, its latency and rsp_rdata hold behaviour.
// Honours STD_SPRAM_INIT_EN the same way as the design.
module tb_std_spram_ctrl;

  // DEPTH=520 gives a 10-bit address, so address 600 is expressible and out of range.
  localparam int unsigned DEPTH = 520;
  localparam int unsigned DW    = 64;
  localparam int unsigned AW    = 10;
  localparam int unsigned NB    = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [NB-1:0] req_be = '0;
  logic [1:0]    rdy, rv, re, busy;
  logic [DW-1:0] rd0, rd1;

  always #5 CLK = ~CLK;

  std_spram_ctrl #(.DEPTH(DEPTH), .DATA_W(DW), .BYTE_W(8), .OUT_REG(0)) u_dut0 (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(rdy[0]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rv[0]),
    .rsp_rdata(rd0), .rsp_err(re[0]), .init_busy(busy[0])
  );

  std_spram_ctrl #(.DEPTH(DEPTH), .DATA_W(DW), .BYTE_W(8), .OUT_REG(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(rdy[1]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rv[1]),
    .rsp_rdata(rd1), .rsp_err(re[1]), .init_busy(busy[1])
  );

  typedef struct {
    int unsigned   acc;   // cycle number of the accepting edge
    logic [DW-1:0] data;
    logic [DW-1:0] mask;  // bits the model actually knows
    logic          err;
  } exp_t;

  logic [DW-1:0] mdl_mem   [DEPTH];
  logic [DW-1:0] mdl_known [DEPTH];
  exp_t          exp_q [$];
  int unsigned   rd_idx [2] = '{0, 0};
  logic [DW-1:0] last_rd [2] = '{64'h0, 64'h0};
  int unsigned   cyc = 0;
  logic          rst_seen = 1'b0;
  int            errors = 0;
  int            checks = 0;

  always @(posedge CLK) begin
    cyc      <= cyc + 1;
    rst_seen <= RST;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic mon(input int idx, input logic v, input logic e, input logic [DW-1:0] d);
    exp_t x;
    if (v) begin
      checks++;
      if (rd_idx[idx] >= exp_q.size()) begin
        errors++;
        $display("FAIL rsp_spurious dut%0d: got rsp_valid rdata=%h, required no response",
                 idx, d);
      end else begin
        x = exp_q[rd_idx[idx]];
        rd_idx[idx]++;
        if (cyc != x.acc + idx) begin
          errors++;
          $display("FAIL rsp_latency dut%0d: got cycle %0d, required %0d", idx, cyc,
                   x.acc + idx);
        end
        chk($sformatf("rsp_err dut%0d", idx), 64'(e), 64'(x.err));
        chk($sformatf("rsp_rdata dut%0d", idx), d & x.mask, x.data & x.mask);
        last_rd[idx] = (x.data & x.mask) | (d & ~x.mask);
      end
    end else begin
      if (rd_idx[idx] < exp_q.size()) begin
        x = exp_q[rd_idx[idx]];
        if (cyc > x.acc + idx) begin
          checks++;
          errors++;
          $display("FAIL rsp_missing dut%0d: got no rsp_valid at cycle %0d, required one",
                   idx, x.acc + idx);
          rd_idx[idx]++;
        end
      end
      chk($sformatf("idle_err dut%0d", idx), 64'(e), 64'h0);
      chk($sformatf("rdata_hold dut%0d", idx), d, last_rd[idx]);
    end
  endtask

  always @(negedge CLK) begin
    if (rst_seen) begin
      last_rd[0] = '0;
      last_rd[1] = '0;
    end
    mon(0, rv[0], re[0], rd0);
    mon(1, rv[1], re[1], rd1);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Applies an accepted request to the model; reads queue their expectation.
  task automatic model_apply(input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wd, input logic [NB-1:0] be,
                             input bit expect_rsp, input int unsigned a);
    exp_t x;
    if (we) begin
      if (addr < DEPTH) begin
        for (int b = 0; b < NB; b++) begin
          if (be[b]) begin
            mdl_mem[addr][b*8 +: 8]   = wd[b*8 +: 8];
            mdl_known[addr][b*8 +: 8] = 8'hFF;
          end
        end
      end
    end else if (expect_rsp) begin
      x.acc = a;
      if (addr >= DEPTH) begin
        x.data = '0;
        x.mask = '1;
        x.err  = 1'b1;
      end else begin
        x.data = mdl_mem[addr];
        x.mask = mdl_known[addr];
        x.err  = 1'b0;
      end
      exp_q.push_back(x);
    end
  endtask

  // Called #1 after a rising edge; leaves req_valid low so callers can chain.
  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input logic [NB-1:0] be, input bit expect_rsp);
    int n = 0;
    while (rdy !== 2'b11 && n < 2000) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (rdy !== 2'b11) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got req_ready=%b, required 11", rdy);
      return;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    model_apply(we, addr, wd, be, expect_rsp, cyc);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
`ifdef STD_SPRAM_INIT_EN
    for (int a = 0; a < DEPTH; a++) begin
      mdl_mem[a]   = '0;
      mdl_known[a] = '1;
    end
    chk("rst_init_busy", 64'(busy), 64'h3);
    chk("rst_req_ready", 64'(rdy), 64'h0);
`else
    chk("rst_init_busy", 64'(busy), 64'h0);
    chk("rst_req_ready", 64'(rdy), 64'h3);
`endif
    chk("rst_rsp_valid", 64'(rv), 64'h0);
    chk("rst_rsp_err", 64'(re), 64'h0);
    chk("rst_rdata0", rd0, 64'h0);
    chk("rst_rdata1", rd1, 64'h0);
  endtask

  task automatic count_busy(input int limit, output int n);
    n = 0;
    while (busy == 2'b11 && n < limit) begin
      chk("ready_in_init", 64'(rdy), 64'h0);
      n++;
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    int n;
    logic [AW-1:0] a;
    for (int i = 0; i < DEPTH; i++) begin
      mdl_mem[i]   = '0;
      mdl_known[i] = '0;
    end
    do_reset();
`ifdef STD_SPRAM_INIT_EN
    // Reset at clear address 200; the full clear must then restart from 0.
    count_busy(200, n);
    chk("init_partial", 64'(n), 64'd200);
    do_reset();
    count_busy(2000, n);
    chk("init_busy_cycles", 64'(n), 64'(DEPTH));
    chk("init_done_ready", 64'(rdy), 64'h3);
    issue(1'b0, AW'(511), '0, '0, 1'b1);
    issue(1'b0, AW'(DEPTH - 1), '0, '0, 1'b1);
`endif
    // Byte-masked write: upper lanes keep 0x11223344.
    issue(1'b1, AW'(5), 64'h1122334455667788, 8'hFF, 1'b1);
    issue(1'b1, AW'(5), 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b1);
    issue(1'b0, AW'(5), '0, '0, 1'b1);
    // All-zero byte enable leaves the word untouched.
    issue(1'b1, AW'(5), 64'hDEADBEEFDEADBEEF, 8'h00, 1'b1);
    issue(1'b0, AW'(5), '0, '0, 1'b1);
    // Back-to-back reads pipeline at one per cycle.
    issue(1'b1, AW'(0), 64'h0000000000000A00, 8'hFF, 1'b1);
    issue(1'b1, AW'(1), 64'h0000000000000B11, 8'hFF, 1'b1);
    issue(1'b1, AW'(2), 64'h0000000000000C22, 8'hFF, 1'b1);
    issue(1'b0, AW'(0), '0, '0, 1'b1);
    issue(1'b0, AW'(1), '0, '0, 1'b1);
    issue(1'b0, AW'(2), '0, '0, 1'b1);
    idle(3);
    // Range boundaries: last valid word, first invalid word, far out of range.
    issue(1'b1, AW'(DEPTH - 1), 64'h5151515151515151, 8'hFF, 1'b1);
    issue(1'b1, AW'(600), 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b1);
    issue(1'b1, AW'(DEPTH), 64'h7777777777777777, 8'hFF, 1'b1);
    issue(1'b0, AW'(600), '0, '0, 1'b1);
    issue(1'b0, AW'(DEPTH - 1), '0, '0, 1'b1);
    issue(1'b0, AW'(DEPTH), '0, '0, 1'b1);
    issue(1'b0, AW'(1023), '0, '0, 1'b1);
    // Write immediately followed by a read of the same word.
    issue(1'b1, AW'(9), 64'h0123456789ABCDEF, 8'hFF, 1'b1);
    issue(1'b0, AW'(9), '0, '0, 1'b1);
    idle(2);
    // Random traffic over a small hot range plus out-of-range addresses.
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 4) == 0) ? AW'($urandom_range(DEPTH, 1023))
                                      : AW'($urandom_range(0, 31));
      issue(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, NB'($urandom), 1'b1);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    // Reset the cycle after a read is accepted: that read must not respond.
    idle(4);
    issue(1'b0, AW'(5), '0, '0, 1'b0);
    do_reset();
    issue(1'b0, AW'(5), '0, '0, 1'b1);
    issue(1'b0, AW'(9), '0, '0, 1'b1);
    idle(6);
    chk("drain_dut0", 64'(rd_idx[0]), 64'(exp_q.size()));
    chk("drain_dut1", 64'(rd_idx[1]), 64'(exp_q.size()));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
